// File: rtl/comparator_bist.sv
// ---------------------------------------------------------------------------
// comparator_bist
// Built-in self test for a 3-bit magnitude comparator. A sweep applies all
// 64 (a, b) operand pairs in ascending order. Each pair is held for
// SETTLE_CYCLES cycles (DRIVE) and then checked for one cycle (CHECK). The
// block counts failing vectors and captures the operands of the first failure.
//
// Control contract: start and abort are level-sampled on each rising clk edge,
// with no handshake. start is accepted only in IDLE or DONE. abort wins over
// start and cancels a running sweep. Results of a cancelled sweep are kept.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a sweep (ignored while busy)
//   abort       cancel the sweep / return to IDLE
//   cmp_gt/eq/lt  outputs of the comparator under test
//   a, b        registered operands driven into the comparator
//   busy        sweep in progress (DRIVE or CHECK)
//   done        sweep finished; held until the next accepted start
//   pass        valid with done; 1 = no failing vectors
//   err_count   number of failing vectors (0..64, saturating)
//   fail_valid  at least one failure captured
//   fail_a/b    operands of the first failing vector
// ---------------------------------------------------------------------------
module comparator_bist #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       cmp_gt,
   input  logic       cmp_eq,
   input  logic       cmp_lt,
   output logic [2:0] a,
   output logic [2:0] b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_a,
   output logic [2:0] fail_b
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [6:0] ERR_MAX     = 7'd64;

   logic [1:0] state;
   logic [5:0] idx;
   logic [3:0] settle;
   logic [2:0] exp_vec;
   logic [2:0] obs_vec;
   logic       vec_err;

   // The operands come straight from the idx flops. idx is forced to 0
   // whenever the FSM returns to IDLE, so a and b read 000 there.
   assign a    = idx[5:3];
   assign b    = idx[2:0];
   assign busy = (state == ST_DRIVE) || (state == ST_CHECK);

   // A whole-vector compare also flags non-one-hot responses
   // (000, 011, 111, ...) as errors.
   always_comb begin
      exp_vec = {(a > b), (a == b), (a < b)};
      obs_vec = {cmp_gt, cmp_eq, cmp_lt};
      vec_err = (obs_vec != exp_vec);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= 6'd0;
         settle     <= 4'd0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 7'd0;
         fail_valid <= 1'b0;
         fail_a     <= 3'd0;
         fail_b     <= 3'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  idx    <= 6'd0;
                  settle <= 4'd0;
                  done   <= 1'b0;
                  pass   <= 1'b0;
               end else if (start) begin
                  state      <= ST_DRIVE;
                  idx        <= 6'd0;
                  settle     <= 4'd0;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= 7'd0;
                  fail_valid <= 1'b0;
                  fail_a     <= 3'd0;
                  fail_b     <= 3'd0;
               end
            end

            ST_DRIVE: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  idx    <= 6'd0;
                  settle <= 4'd0;
               end else if (settle == SETTLE_LAST) begin
                  state  <= ST_CHECK;
                  settle <= 4'd0;
               end else begin
                  settle <= settle + 4'd1;
               end
            end

            ST_CHECK: begin
               if (abort) begin
                  // The result of this vector is dropped; the
                  // accumulated error info stays visible.
                  state  <= ST_IDLE;
                  idx    <= 6'd0;
                  settle <= 4'd0;
               end else begin
                  if (vec_err) begin
                     if (err_count != ERR_MAX)
                        err_count <= err_count + 7'd1;
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a;
                        fail_b     <= b;
                     end
                  end
                  if (idx == 6'd63) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     // err_count has not yet absorbed this vector's result.
                     pass  <= (err_count == 7'd0) && !vec_err;
                  end else begin
                     state <= ST_DRIVE;
                     idx   <= idx + 6'd1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               idx   <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_bist.sv
// ---------------------------------------------------------------------------
// tb_comparator_bist
// Directed bench for comparator_bist. dut1 uses the default SETTLE_CYCLES=1
// and is fed by a comparator model with selectable faults. dut2 uses
// SETTLE_CYCLES=3 and is fed by a correct comparator model.
// ---------------------------------------------------------------------------
module tb_comparator_bist;

   logic clk;
   logic rst_n;
   logic start, abort, start2, abort2;
   logic cmp_gt, cmp_eq, cmp_lt, cmp_gt2, cmp_eq2, cmp_lt2;
   logic [2:0] a, b, a2, b2;
   logic busy, done, pass, busy2, done2, pass2;
   logic [6:0] err_count, err_count2;
   logic fail_valid, fail_valid2;
   logic [2:0] fail_a, fail_b, fail_a2, fail_b2;

   // Fault mode: 0 = correct, 1 = eq stuck at 0, 2 = gt/lt swapped
   int mode;
   int n_tests;
   int n_fail;

   comparator_bist dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid),
      .fail_a(fail_a), .fail_b(fail_b)
   );

   comparator_bist #(.SETTLE_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .cmp_gt(cmp_gt2), .cmp_eq(cmp_eq2), .cmp_lt(cmp_lt2),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .fail_valid(fail_valid2),
      .fail_a(fail_a2), .fail_b(fail_b2)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparator models
   always_comb begin
      case (mode)
         1:       {cmp_gt, cmp_eq, cmp_lt} = {(a > b), 1'b0, (a < b)};
         2:       {cmp_gt, cmp_eq, cmp_lt} = {(a < b), (a == b), (a > b)};
         default: {cmp_gt, cmp_eq, cmp_lt} = {(a > b), (a == b), (a < b)};
      endcase
   end

   always_comb begin
      {cmp_gt2, cmp_eq2, cmp_lt2} = {(a2 > b2), (a2 == b2), (a2 < b2)};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Called just after the accepted start edge. Checks {busy,done,a,b} every
   // cycle of the sweep, then the done edge at exactly 64*(settle+1) cycles.
   // repulse_at >= 0 raises start for one cycle at that offset.
   task automatic track_sweep(input int settle, input bit use2, input int repulse_at);
      int n;
      logic [5:0] ix;
      logic [7:0] obs;
      n = 64 * (settle + 1);
      for (int i = 0; i < n; i++) begin
         ix  = 6'(i / (settle + 1));
         obs = use2 ? {busy2, done2, a2, b2} : {busy, done, a, b};
         check("sweep_step", 32'(obs), 32'({1'b1, 1'b0, ix[5:3], ix[2:0]}));
         if (i == repulse_at) begin
            if (use2) start2 = 1'b1; else start = 1'b1;
         end
         tick();
         start  = 1'b0;
         start2 = 1'b0;
      end
      obs = use2 ? {busy2, done2, 6'd0} : {busy, done, 6'd0};
      check("done_edge", 32'(obs), 32'h40);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [22:0] all_out;
   assign all_out = {a, b, busy, done, pass, err_count, fail_valid, fail_a, fail_b};

   initial begin
      n_tests = 0;
      n_fail  = 0;
      mode    = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      start2  = 1'b0;
      abort2  = 1'b0;

      // Reset state
      #3;
      check("reset_outputs", 32'(all_out), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("idle_after_reset", 32'(all_out), 32'h0);

      // Correct comparator: pass at start+128
      pulse_start();
      track_sweep(1, 1'b0, -1);
      check("good_pass", 32'(pass), 32'h1);
      check("good_err", 32'(err_count), 32'h0);
      check("good_fail_valid", 32'(fail_valid), 32'h0);

      // eq stuck at 0: 8 errors, first at (0,0)
      mode = 1;
      pulse_start();
      check("restart_clears_done", 32'({done, pass, err_count}), 32'h0);
      track_sweep(1, 1'b0, -1);
      check("eq0_err", 32'(err_count), 32'd8);
      check("eq0_pass", 32'(pass), 32'h0);
      check("eq0_fail", 32'({fail_valid, fail_a, fail_b}), 32'({1'b1, 3'd0, 3'd0}));

      // abort in DONE returns to IDLE and drops done/pass
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_done", 32'({busy, done, pass, err_count}), 32'({3'b000, 7'd8}));

      // gt/lt swapped: 56 errors, first at (0,1)
      mode = 2;
      pulse_start();
      track_sweep(1, 1'b0, -1);
      check("swap_err", 32'(err_count), 32'd56);
      check("swap_pass", 32'(pass), 32'h0);
      check("swap_fail", 32'({fail_valid, fail_a, fail_b}), 32'({1'b1, 3'd0, 3'd1}));

      // abort during CHECK of vector 1 discards that vector's error
      pulse_start();
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_check", 32'({busy, done, a, b, err_count, fail_valid}), 32'h0);

      // abort during DRIVE of vector 5: vectors 1..4 already counted
      pulse_start();
      repeat (10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_drive_state", 32'({busy, done, a, b}), 32'h0);
      check("abort_drive_err", 32'({err_count, fail_valid, fail_a, fail_b}),
            32'({7'd4, 1'b1, 3'd0, 3'd1}));

      // start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 32'({busy, done, err_count}), 32'({2'b00, 7'd4}));

      // fresh sweep after abort restarts the count
      mode = 0;
      pulse_start();
      check("restart_err_zero", 32'({err_count, fail_valid}), 32'h0);
      track_sweep(1, 1'b0, -1);
      check("restart_pass", 32'({pass, err_count}), 32'({1'b1, 7'd0}));

      // start re-pulsed at vector 10 is ignored
      pulse_start();
      track_sweep(1, 1'b0, 20);
      check("repulse_pass", 32'(pass), 32'h1);

      // asynchronous reset at vector 20
      pulse_start();
      repeat (40) tick();
      check("pre_reset_vec20", 32'({busy, a, b}), 32'({1'b1, 3'd2, 3'd4}));
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'(all_out), 32'h0);
      repeat (2) tick();
      check("reset_held", 32'(all_out), 32'h0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_after_release", 32'(all_out), 32'h0);

      // SETTLE_CYCLES=3 instance: 4 cycles per vector, done at start+256
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      track_sweep(3, 1'b1, -1);
      check("settle3_result", 32'({pass2, err_count2, fail_valid2}), 32'({1'b1, 7'd0, 1'b0}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
